// File: rtl/mfp_uart_receiver.sv
// Purpose: 8N1 UART receiver with a one-entry valid/ready output register and error pulses.
// Latency: rx_valid rises the cycle after the mid-stop-bit sample (about 9.5 bit times after the start edge).
// Backpressure: reception never stalls; a byte completing while the output is still held is dropped and flagged by overrun.
//
// Ports:
//   HCLK        - single clock, rising edge
//   HRESETn     - asynchronous active-low reset
//   UART_RX     - asynchronous serial input, idle high, LSB first
//   rx_data     - last received byte (stable while rx_valid and not consumed)
//   rx_valid    - rx_data holds an unconsumed byte
//   rx_ready    - consumer accepts rx_data when rx_valid is also high
//   frame_error - one-cycle pulse when a stop bit is sampled low
//   overrun     - one-cycle pulse when a completed byte is dropped
module mfp_uart_receiver #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       UART_RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_error_q, frame_error_d;
    logic             overrun_q, overrun_d;

    logic             rx_s;
    logic             byte_done;
    logic             consume;

    assign rx_s    = sync2_q;
    assign consume = rx_valid_q & rx_ready;

    always_comb begin
        state_d       = state_q;
        sync1_d       = UART_RX;
        sync2_d       = sync1_q;
        rx_prev_d     = rx_s;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;
        byte_done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Start bit is a falling edge of the synchronized line.
                if (rx_prev_q && !rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Re-check mid start bit so short low glitches are ignored.
                if (cnt_q == HALF_M1) begin
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        cnt_d     = '0;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                // Counter was aligned to mid start bit, so full-bit steps land mid data bit.
                if (cnt_q == FULL_M1) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                // A held-low line (break) must return high before a new start is looked for.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output register: a completing byte may replace one being consumed on
        // the same edge; otherwise a pending byte wins and the new one is dropped.
        if (byte_done) begin
            if (!rx_valid_q || consume) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (consume) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= S_IDLE;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            cnt_q         <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            rx_prev_q     <= rx_prev_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_mfp_uart_receiver.sv
// Purpose: scoreboard bench for mfp_uart_receiver with directed serial frames.
// Latency: expected bytes are queued at send time and popped when the DUT presents a new byte.
// Backpressure: rx_ready is driven by the stimulus thread to exercise hold, consume and overrun.
module tb_mfp_uart_receiver;

    localparam int CPB = 16;

    logic       HCLK;
    logic       HRESETn;
    logic       UART_RX;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_error;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int last_pres_cyc = 0;

    logic [7:0] exp_q[$];

    mfp_uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .UART_RX     (UART_RX),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc++;

    // Monitor: a new byte is presented when rx_valid is seen high after being
    // low or after a handshake on the previous edge.
    logic       last_valid = 1'b0;
    logic       last_took  = 1'b0;
    logic [7:0] last_data  = 8'h00;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            last_valid = 1'b0;
            last_took  = 1'b0;
        end else begin
            if (rx_valid === 1'b1 && (!last_valid || last_took)) begin
                total++;
                last_pres_cyc = cyc;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_byte: got %h, required no byte", rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        bad++;
                        $display("FAIL rx_byte: got %h, required %h", rx_data, e);
                    end
                end
            end else if (rx_valid === 1'b1 && last_valid && !last_took) begin
                total++;
                if (rx_data !== last_data) begin
                    bad++;
                    $display("FAIL data_hold: got %h, required %h", rx_data, last_data);
                end
            end
            if (frame_error === 1'b1) fe_cnt++;
            if (overrun === 1'b1) ov_cnt++;
            last_valid = (rx_valid === 1'b1);
            last_took  = (rx_valid === 1'b1) && (rx_ready === 1'b1);
            last_data  = rx_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // Drive the line for n clock cycles; entered and left just after a rising edge.
    task automatic hold(input logic v, input int n);
        UART_RX = v;
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(1'b1, CPB);
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        @(posedge HCLK); #1;
        rx_ready = 1'b0;
    endtask

    int t0;
    int fe0;
    int ov0;

    initial begin
        HRESETn  = 1'b0;
        UART_RX  = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge HCLK); #1;

        // Reset state
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        chk("reset_frame_error", 32'(frame_error), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        HRESETn = 1'b1;
        hold(1'b1, 5);

        // 0xA5 with rx_ready low: held until a single-cycle ready
        t0 = cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5);
        chk("a5_latency_window", 32'((last_pres_cyc - t0) >= 150 && (last_pres_cyc - t0) <= 160), 32'd1);
        hold(1'b1, 20);
        chk("a5_still_valid", 32'(rx_valid), 32'd1);
        chk("a5_still_data", 32'(rx_data), 32'hA5);
        pulse_ready();
        chk("a5_consumed", 32'(rx_valid), 32'd0);

        // 4-cycle low glitch on idle line
        fe0 = fe_cnt;
        hold(1'b0, 4);
        hold(1'b1, 3 * CPB);
        chk("glitch_no_valid", 32'(rx_valid), 32'd0);
        chk("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);

        // 0x3C with stop low for 3 bit times, then 0x55
        fe0 = fe_cnt;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(8'h3C >> i, CPB);
        hold(1'b0, 3 * CPB);
        hold(1'b1, 2 * CPB);
        chk("break_one_fe", 32'(fe_cnt - fe0), 32'd1);
        chk("break_no_valid", 32'(rx_valid), 32'd0);
        exp_q.push_back(8'h55);
        send_frame(8'h55);
        hold(1'b1, 4);
        chk("after_break_valid", 32'(rx_valid), 32'd1);
        pulse_ready();

        // Back-to-back 0x11, 0x22 with rx_ready low: second is dropped
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11);
        send_frame(8'h22);
        hold(1'b1, 4);
        chk("overrun_one_pulse", 32'(ov_cnt - ov0), 32'd1);
        chk("overrun_keeps_old", 32'(rx_data), 32'h11);
        pulse_ready();
        chk("overrun_consumed", 32'(rx_valid), 32'd0);

        // Same bytes with rx_ready held high: both delivered, no overrun
        ov0 = ov_cnt;
        rx_ready = 1'b1;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11);
        send_frame(8'h22);
        hold(1'b1, 4);
        chk("ready_high_no_overrun", 32'(ov_cnt - ov0), 32'd0);
        chk("ready_high_queue_drained", 32'(exp_q.size()), 32'd0);
        rx_ready = 1'b0;

        // Reset during data bit 4 of 0xFF
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(1'b1, CPB);
        hold(1'b1, CPB / 2);
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        chk("midreset_rx_valid", 32'(rx_valid), 32'd0);
        chk("midreset_rx_data", 32'(rx_data), 32'h00);
        chk("midreset_fe", 32'(frame_error), 32'd0);
        chk("midreset_ov", 32'(overrun), 32'd0);
        HRESETn = 1'b1;
        hold(1'b1, CPB / 2 + 3 * CPB + CPB);
        chk("midreset_no_output", 32'(rx_valid), 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81);
        hold(1'b1, 4);
        chk("after_reset_valid", 32'(rx_valid), 32'd1);
        chk("after_reset_data", 32'(rx_data), 32'h81);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("total_frame_errors", 32'(fe_cnt), 32'd1);
        chk("total_overruns", 32'(ov_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mfp_uart_receiver.md
MFP_UART_RECEIVER -- requirements
Module: mfp_uart_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning HCLK cycles per serial bit (50 MHz / 115200 baud); legal values are even and at least 8.
REQ-002 The block SHALL have port HCLK  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port HRESETn  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port UART_RX  input  1  asynchronous serial line in 8N1 format, idle high, LSB first.
REQ-005 The block SHALL have port rx_data  output  8  last received byte.
REQ-006 The block SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 The block SHALL have port rx_ready  input  1  consumer accepts rx_data when rx_valid is also high.
REQ-008 The block SHALL have port frame_error  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 The block SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-010 UART_RX SHALL pass through a two-flop synchronizer, reset value 1; all logic below uses the synchronized value (rx_s).
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE, with a bit-timing counter of width clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-012 IDLE: a high-to-low transition of rx_s SHALL move to START and clear the counter.
REQ-013 START: rx_s SHALL be sampled when the counter reaches CLKS_PER_BIT/2-1; if low, go to DATA and clear the counter and bit index; if high (glitch), return to IDLE with no output.
REQ-014 DATA: rx_s SHALL be sampled when the counter reaches CLKS_PER_BIT-1 and shifted in LSB first; after bit index 7, go to STOP.
REQ-015 STOP: rx_s SHALL be sampled CLKS_PER_BIT-1 cycles after entry; high completes the byte and returns to IDLE.
REQ-016 STOP: a low stop bit SHALL pulse frame_error for one cycle, discard the byte, and go to WAIT_IDLE.
REQ-017 WAIT_IDLE SHALL hold until rx_s is high, then return to IDLE (break conditions produce exactly one frame_error).
REQ-018 On byte completion, rx_data and rx_valid=1 SHALL update on the cycle after the stop-bit sample.
REQ-019 Handshake: rx_valid and rx_ready both high at a rising edge SHALL consume the byte, clearing rx_valid on that edge unless a new byte loads on the same edge.
REQ-020 On completion with rx_valid=1 and rx_ready=1 on the same edge, the new byte SHALL load, rx_valid SHALL stay 1, and overrun SHALL stay 0.
REQ-021 On completion with rx_valid=1 and rx_ready=0, the new byte SHALL be dropped, rx_data SHALL keep the old byte, and overrun SHALL pulse once.
REQ-022 rx_data SHALL remain stable while rx_valid=1 and no consume occurs.
REQ-023 Reception SHALL proceed independently of rx_ready; a back-to-back start bit immediately after the stop sample SHALL be detected.

Reset
REQ-024 HRESETn low SHALL immediately force state IDLE, counters 0, shift register 0, synchronizer flops 1, rx_data=8'h00, rx_valid=0, frame_error=0, overrun=0.
REQ-025 Release of reset mid-frame SHALL leave the block in IDLE; the partial frame produces no output, and any following falling edge is treated as a start bit.

Verification (bench CLKS_PER_BIT=16)
REQ-026 Serial 0xA5 (start, 1,0,1,0,0,1,0,1, stop), rx_ready=0 -> rx_valid=1 and rx_data=8'hA5 about 2+8+8*16+16 cycles after the start edge; they hold until rx_ready=1 for one cycle, then rx_valid=0.
REQ-027 Low glitch of 4 cycles on idle line -> no rx_valid, no frame_error, and the FSM is back in IDLE.
REQ-028 Byte 0x3C with stop bit low for 3 bit times -> exactly one frame_error pulse, rx_valid stays 0, and the next valid byte 0x55 is received correctly.
REQ-029 Bytes 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_data=8'h11, one overrun pulse at the 0x22 completion; with rx_ready held 1 instead -> 0x11 and 0x22 both delivered and no overrun.
REQ-030 HRESETn asserted during data bit 4 of 0xFF, then released -> all outputs are at reset values, no rx_valid for that frame, and the next 0x81 is received correctly.
